// File: rtl/hiss_rx_serializer_pkg.sv
// HISS RX serializer shared types.
// FSM encoding and counter sizing helper.
package hiss_rx_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_TAIL   = 2'd3
  } hiss_state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hiss_rx_serializer_fifo.sv
// Sample-pair FIFO for the HISS RX serializer.
// Push is refused when full, even alongside a pop.
module hiss_rx_serializer_fifo #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         wdata,
  output logic [W-1:0]         rdata,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   level
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(D));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hiss_rx_serializer.sv
// HISS RX serializer: FIFO-buffered I/Q pairs shifted MSB-first
// onto the pad with a forwarded bit clock and sequenced enables.
module hiss_rx_serializer
  import hiss_rx_serializer_pkg::*;
#(
  parameter int SAMPLE_W    = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HALF_CYC    = 2,
  parameter int WARMUP_BITS = 4,
  parameter int TAIL_BITS   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_i,
  input  logic [SAMPLE_W-1:0]           s_q,
  output logic                          hiss_rxi,
  output logic                          hiss_rxq,
  output logic                          hiss_clk,
  output logic                          hiss_rxien,
  output logic                          hiss_rxqen,
  output logic                          hiss_clken,
  output logic                          busy,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PER = 2 * HALF_CYC;
  localparam int PW  = cnt_w(PER);
  localparam int BW  = cnt_w(SAMPLE_W + WARMUP_BITS + TAIL_BITS);

  hiss_state_t           state_q;
  hiss_state_t           state_d;
  logic [PW-1:0]         ph_q;
  logic [PW-1:0]         ph_d;
  logic [BW-1:0]         bc_q;
  logic [BW-1:0]         bc_d;
  logic [SAMPLE_W-1:0]   shi_q;
  logic [SAMPLE_W-1:0]   shi_d;
  logic [SAMPLE_W-1:0]   shq_q;
  logic [SAMPLE_W-1:0]   shq_d;
  logic [2*SAMPLE_W-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  und_d;
  logic                  pend;
  logic                  have;

  hiss_rx_serializer_fifo #(
    .W (2*SAMPLE_W),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (pop),
    .wdata ({s_i, s_q}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign s_ready = ~full;
  assign busy    = (state_q != ST_IDLE);
  assign pend    = (ph_q == PW'(PER-1));
  assign have    = en & ~empty;

  always_comb begin
    state_d = state_q;
    ph_d    = '0;
    bc_d    = bc_q;
    shi_d   = shi_q;
    shq_d   = shq_q;
    pop     = 1'b0;
    und_d   = 1'b0;
    if (state_q != ST_IDLE)
      ph_d = pend ? '0 : ph_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (have) begin
          state_d = ST_WARMUP;
          bc_d    = '0;
        end
      end
      ST_WARMUP: begin
        if (pend) begin
          if (bc_q == BW'(WARMUP_BITS-1)) begin
            bc_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_TAIL;
            end
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (pend) begin
          if (bc_q == BW'(SAMPLE_W-1)) begin
            bc_d = '0;
            if (have) begin
              pop = 1'b1;
            end else begin
              state_d = ST_TAIL;
              und_d   = en;
            end
          end else begin
            bc_d  = bc_q + 1'b1;
            shi_d = {shi_q[SAMPLE_W-2:0], 1'b0};
            shq_d = {shq_q[SAMPLE_W-2:0], 1'b0};
          end
        end
      end
      ST_TAIL: begin
        if (pend) begin
          if (have) begin
            pop     = 1'b1;
            state_d = ST_SHIFT;
            bc_d    = '0;
          end else if (bc_q == BW'(TAIL_BITS-1)) begin
            state_d = ST_IDLE;
            bc_d    = '0;
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) {shi_d, shq_d} = head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bc_q    <= '0;
      shi_q   <= '0;
      shq_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bc_q    <= bc_d;
      shi_q   <= shi_d;
      shq_q   <= shq_d;
    end
  end

  // pad flops load from next-state values so they align with the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hiss_rxi   <= 1'b0;
      hiss_rxq   <= 1'b0;
      hiss_clk   <= 1'b0;
      hiss_rxien <= 1'b0;
      hiss_rxqen <= 1'b0;
      hiss_clken <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      hiss_rxi   <= (state_d == ST_SHIFT) & shi_d[SAMPLE_W-1];
      hiss_rxq   <= (state_d == ST_SHIFT) & shq_d[SAMPLE_W-1];
      hiss_clk   <= (state_d != ST_IDLE) & (ph_d >= PW'(HALF_CYC));
      hiss_rxien <= (state_d != ST_IDLE);
      hiss_rxqen <= (state_d != ST_IDLE);
      hiss_clken <= (state_d != ST_IDLE);
      underrun   <= und_d;
    end
  end

endmodule

// File: tb/tb_hiss_rx_serializer.sv
// Bench for hiss_rx_serializer: directed sequences, a vector table
// and a period-queue reference model compared every cycle.
module tb_hiss_rx_serializer;

  localparam int SW  = 8;
  localparam int D   = 4;
  localparam int H   = 2;
  localparam int WB  = 4;
  localparam int TB  = 2;
  localparam int PER = 2 * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] s_i;
  logic [SW-1:0] s_q;
  logic          hiss_rxi;
  logic          hiss_rxq;
  logic          hiss_clk;
  logic          hiss_rxien;
  logic          hiss_rxqen;
  logic          hiss_clken;
  logic          busy;
  logic          underrun;
  logic [2:0]    fifo_level;
  logic [11:0]   dutv;

  always #5 clk = ~clk;

  hiss_rx_serializer #(
    .SAMPLE_W    (SW),
    .FIFO_DEPTH  (D),
    .HALF_CYC    (H),
    .WARMUP_BITS (WB),
    .TAIL_BITS   (TB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_i        (s_i),
    .s_q        (s_q),
    .hiss_rxi   (hiss_rxi),
    .hiss_rxq   (hiss_rxq),
    .hiss_clk   (hiss_clk),
    .hiss_rxien (hiss_rxien),
    .hiss_rxqen (hiss_rxqen),
    .hiss_clken (hiss_clken),
    .busy       (busy),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  assign dutv = {s_ready, hiss_rxi, hiss_rxq, hiss_clk,
                 hiss_rxien, hiss_rxqen, hiss_clken,
                 busy, underrun, fifo_level};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of upcoming bit periods.
  // kind 0 = warm-up, 1 = data, 2 = tail.
  typedef struct {
    int kind;
    bit i;
    bit q;
  } per_t;

  per_t          pq[$];
  logic [2*SW-1:0] mq[$];
  bit            m_act = 0;
  int            m_pos = 0;
  bit            m_unr = 0;

  task automatic m_load();
    logic [2*SW-1:0] w;
    w = mq.pop_front();
    for (int b = SW - 1; b >= 0; b--)
      pq.push_back('{1, w[SW+b], w[b]});
  endtask

  task automatic m_tails();
    for (int k = 0; k < TB; k++) pq.push_back('{2, 1'b0, 1'b0});
  endtask

  task automatic m_step();
    bit   rdy;
    bit   have;
    per_t f;
    rdy   = mq.size() < D;
    have  = en && mq.size() > 0;
    m_unr = 0;
    if (!m_act) begin
      if (have) begin
        m_act = 1;
        m_pos = 0;
        for (int k = 0; k < WB; k++) pq.push_back('{0, 1'b0, 1'b0});
      end
    end else if (m_pos == PER - 1) begin
      m_pos = 0;
      f = pq.pop_front();
      if (f.kind == 2 && have) begin
        pq.delete();
        m_load();
      end else if (pq.size() == 0) begin
        if (f.kind == 0 && mq.size() > 0) m_load();
        else if (f.kind == 1 && have) m_load();
        else if (f.kind == 1) begin
          m_unr = en;
          m_tails();
        end else if (f.kind == 0) m_tails();
        else m_act = 0;
      end
    end else begin
      m_pos++;
    end
    if (s_valid && rdy) mq.push_back({s_i, s_q});
  endtask

  function automatic logic [11:0] m_exp();
    bit ck;
    bit di;
    bit dq;
    ck = m_act && (m_pos >= H);
    di = (m_act && pq.size() > 0) ? pq[0].i : 1'b0;
    dq = (m_act && pq.size() > 0) ? pq[0].q : 1'b0;
    return {mq.size() < D, di, dq, ck, m_act, m_act, m_act,
            m_act, m_unr, 3'(mq.size())};
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pq.delete();
      mq.delete();
      m_act = 0;
      m_pos = 0;
      m_unr = 0;
    end else begin
      m_step();
    end
  end

  int busy_cyc = 0;
  int unr_cnt  = 0;
  int falls    = 0;
  bit prev_b   = 0;

  initial forever begin
    @(negedge clk);
    chk("model", dutv, m_exp());
    busy_cyc += int'(busy);
    unr_cnt  += int'(underrun);
    if (prev_b && !busy) falls++;
    prev_b = busy;
  end

  task automatic clr_stats();
    busy_cyc = 0;
    unr_cnt  = 0;
    falls    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    en      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int t;
    bit seen;
    bit ok;
    t    = 0;
    seen = 0;
    ok   = 0;
    while (t < maxc && !ok) begin
      @(negedge clk);
      seen |= busy;
      ok = seen && !busy;
      t++;
    end
    chk({nm, "_done"}, 32'(ok), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic push1(input logic [SW-1:0] i, input logic [SW-1:0] q);
    s_valid = 1'b1;
    s_i     = i;
    s_q     = q;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  typedef struct {
    logic          sv;
    logic [SW-1:0] i;
    logic [SW-1:0] q;
    logic          rdy;
    logic [2:0]    lvl;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [SW-1:0] vi;
    logic [SW-1:0] vq;
    int t;
    int we;
    int se;
    int te;

    vt[0] = '{1'b1, 8'h11, 8'h81, 1'b1, 3'd1};
    vt[1] = '{1'b1, 8'h22, 8'h42, 1'b1, 3'd2};
    vt[2] = '{1'b1, 8'h33, 8'h24, 1'b1, 3'd3};
    vt[3] = '{1'b1, 8'h44, 8'h18, 1'b0, 3'd4};
    vt[4] = '{1'b1, 8'h55, 8'hFF, 1'b0, 3'd4};
    vt[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd4};

    rst = 1'b1;
    en = 1'b0;
    s_valid = 1'b0;
    s_i = '0;
    s_q = '0;
    do_reset();
    chk("reset_vec", dutv, 12'b1000_0000_0000);

    // single word A5/3C with exact cycle timeline
    vi = 8'hA5;
    vq = 8'h3C;
    we = 2 + WB * PER;
    se = we + SW * PER;
    te = se + TB * PER;
    en = 1'b1;
    push1(vi, vq);
    for (int k = 1; k <= te + 4; k++) begin
      bit on;
      bit ck;
      bit di;
      bit dq;
      int b;
      on = (k >= 2) && (k < te);
      ck = on && (((k - 2) % PER) >= H);
      di = 1'b0;
      dq = 1'b0;
      if (k >= we && k < se) begin
        b  = SW - 1 - (k - we) / PER;
        di = vi[b];
        dq = vq[b];
      end
      chk($sformatf("t2_k%0d", k), dutv,
          {1'b1, di, dq, ck, on, on, on, on, k == se,
           3'((k < we) ? 1 : 0)});
      @(negedge clk);
    end

    // three back-to-back words: one warm-up, one tail
    do_reset();
    clr_stats();
    en = 1'b1;
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_i = 8'(k * 37 + 5);
      s_q = 8'(k * 91 + 3);
      @(negedge clk);
    end
    s_valid = 1'b0;
    wait_done("t3", 400);
    chk("t3_busy_cyc", busy_cyc, (WB + 3 * SW + TB) * PER);
    chk("t3_underrun", unr_cnt, 1);
    chk("t3_falls", falls, 1);

    // fill with en=0, table-driven
    do_reset();
    for (int r = 0; r < 6; r++) begin
      s_valid = vt[r].sv;
      s_i = vt[r].i;
      s_q = vt[r].q;
      @(negedge clk);
      chk($sformatf("t4_rdy%0d", r), s_ready, vt[r].rdy);
      chk($sformatf("t4_lvl%0d", r), fifo_level, vt[r].lvl);
    end
    s_valid = 1'b0;
    clr_stats();
    en = 1'b1;
    wait_done("t4", 400);
    chk("t4_busy_cyc", busy_cyc, (WB + 4 * SW + TB) * PER);
    chk("t4_level", fifo_level, 0);

    // en dropped during bit 3 of the first word
    do_reset();
    for (int k = 0; k < 3; k++) push1(8'(k + 8'hC0), 8'(k + 8'h0E));
    clr_stats();
    en = 1'b1;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t5_start", busy, 1);
    repeat (WB * PER + (SW - 1 - 3) * PER + 1) @(negedge clk);
    en = 1'b0;
    wait_done("t5", 200);
    chk("t5_level", fifo_level, 2);
    chk("t5_underrun", unr_cnt, 0);
    chk("t5_busy_cyc", busy_cyc, (WB + SW + TB) * PER);

    // push during tail resumes without warm-up
    do_reset();
    en = 1'b1;
    clr_stats();
    push1(8'h96, 8'h69);
    t = 0;
    while (!underrun && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t6_first_underrun", underrun, 1);
    push1(8'h5A, 8'hC3);
    wait_done("t6", 400);
    chk("t6_busy_cyc", busy_cyc, (WB + SW + 1 + SW + TB) * PER);
    chk("t6_underrun", unr_cnt, 2);
    chk("t6_falls", falls, 1);

    // async reset mid-burst
    do_reset();
    en = 1'b1;
    push1(8'hF0, 8'h0F);
    push1(8'h12, 8'h34);
    repeat (30) @(negedge clk);
    chk("t1_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_async", dutv, 12'b1000_0000_0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_after", dutv, 12'b1000_0000_0000);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      s_valid = ($urandom_range(0, 2) == 0);
      s_i = 8'($urandom);
      s_q = 8'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b0;
    en = 1'b1;
    repeat (300) @(negedge clk);
    chk("rand_level", fifo_level, 0);
    chk("rand_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
